remote_cmd_sequencer: RTL and testbench
=======================================

# remote_cmd_sequencer

Parametrised host-side command sequencer for the Knight's Tour UART link. It queues multi-byte commands in a FIFO and sends each one MSB-first over an existing byte-level UART transceiver. After each command it waits for a one-byte response within a cycle timeout, and retries or drops the command on a negative acknowledge or timeout. It sits between a stimulus/control source and the UART, replacing the single-command send-and-wait handshake with buffered, self-checking operation.

## Interface
- CMD_BYTES, 2: bytes per command; command width is 8*CMD_BYTES; legal range 1–4.
- DEPTH, 8: FIFO entries; power of two, 2–64.
- TIMEOUT_CLKS, 1000000: clocks allowed from the last byte's tx_done to rx_rdy.
- MAX_RETRY, 0: resends allowed after a NACK or timeout before the command is dropped.
- ACK, 8'hA5: response byte treated as a positive acknowledge.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_in  in  8*CMD_BYTES  command to enqueue.
- cmd_vld  in  1  enqueue request.
- cmd_rdy  out  1  FIFO not full; a push happens when cmd_vld and cmd_rdy are both high.
- flush  in  1  discards all queued commands except the one in flight.
- tx_data  out  8  byte to the UART transmitter.
- trmt  out  1  one-cycle transmit strobe.
- tx_done  in  1  transmitter finished the current byte.
- rx_data  in  8  received byte.
- rx_rdy  in  1  received byte valid; level, held until cleared.
- clr_rx_rdy  out  1  one-cycle clear of rx_rdy.
- busy  out  1  FSM is not in IDLE.
- resp  out  8  last received response byte.
- resp_vld  out  1  one-cycle pulse when resp updates.
- ack_cnt, nack_cnt, tmo_cnt  out  16 each  saturating counters of completed commands.

## Operation
- FSM states: IDLE, SEND, WAIT_TX, WAIT_RESP.
- IDLE → SEND when the FIFO is not empty. The head entry is latched into a shift register and the byte index is cleared to 0.
- SEND:
  - trmt=1 for one cycle.
  - tx_data = current byte, MSB byte first; tx_data holds until the next SEND.
  - Then → WAIT_TX.
- WAIT_TX, on tx_done:
  - If bytes remain → SEND.
  - Otherwise → WAIT_RESP; the timeout counter clears and the retry count is unchanged.
- WAIT_RESP, on rx_rdy:
  - resp=rx_data, resp_vld=1, clr_rx_rdy=1 for one cycle.
  - If rx_data==ACK: ack_cnt+1, pop the FIFO, clear the retry count, → IDLE.
  - Otherwise it is a NACK: if retry<MAX_RETRY, retry+1 and → SEND with byte index 0 and the same latched command. Else nack_cnt+1, pop, clear the retry count, → IDLE.
- WAIT_RESP, timeout counter reaching TIMEOUT_CLKS-1 without rx_rdy: same retry/drop rule as a NACK; on drop tmo_cnt+1. resp and resp_vld are unchanged.
- rx_rdy in any state other than WAIT_RESP is a stray byte: clr_rx_rdy pulses and the byte is ignored. resp, resp_vld and the counters are unchanged.
- rx_rdy and a timeout in the same cycle: rx_rdy wins.
- FIFO:
  - cmd_rdy = !full.
  - A push while full is ignored, even in a pop cycle.
  - Push and pop in the same cycle with the FIFO not full: both take effect and the count is unchanged.
  - Pointers wrap modulo DEPTH; a count register of width log2(DEPTH)+1 distinguishes full from empty.
- flush, one cycle:
  - Not busy: empties the FIFO.
  - Busy: keeps only the in-flight head; it completes normally and is popped, leaving the FIFO empty.
  - A push in the same cycle as flush is discarded.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: cmd_rdy=1; tx_data=0; trmt=0; clr_rx_rdy=0; busy=0; resp=0; resp_vld=0; all counters 0; FIFO empty; state IDLE.
- Reset asserted mid-command abandons the command: no counter update, and nothing is resent after release.
- Push at edge N: the FIFO is non-empty at N+1, the FSM enters SEND at N+2, and trmt is high during the cycle after N+2.
- Byte k+1's trmt is exactly 2 cycles after the tx_done of byte k.
- resp_vld and clr_rx_rdy are high in the cycle after rx_rdy is sampled in WAIT_RESP.
- The pop and counter updates take effect on the same edge that asserts resp_vld.
- Timeout is measured from the last tx_done; a drop occurs exactly TIMEOUT_CLKS cycles later.
- busy is 0 in the cycle after the terminating response or timeout.

## Test plan
- CMD_BYTES=2; push 16'h2000; answer with A5 → trmt carries bytes 20 then 00; ack_cnt=1; busy falls; cmd_rdy=1.
- DEPTH=4; push 5 commands back-to-back while the transmitter is stalled → cmd_rdy falls after the 4th push, the 5th push is ignored, and the 4 commands are sent in order.
- MAX_RETRY=1; respond 5A then A5 → the command is sent twice; ack_cnt=1; nack_cnt=0; resp=A5.
- MAX_RETRY=0; TIMEOUT_CLKS=100; never respond → tmo_cnt=1 exactly 100 cycles after the last tx_done; the next command starts.
- Stray rx_rdy while IDLE → clr_rx_rdy pulses; resp stays 0; no counter changes. flush with 3 queued during the 1st command's WAIT_RESP → only 1 command completes, and the FIFO is empty afterwards.
- Assert rst_n low during WAIT_TX → all outputs return to their reset values immediately; no trmt after release.

Source files
------------

// File: rtl/remote_cmd_sequencer.sv
// Buffered command sequencer for the Knight's Tour UART link: queues commands,
// sends them MSB byte first, then waits for a one-byte ACK with retry/timeout.
module remote_cmd_sequencer #(
    parameter int         CMD_BYTES    = 2,
    parameter int         DEPTH        = 8,
    parameter int         TIMEOUT_CLKS = 1000000,
    parameter int         MAX_RETRY    = 0,
    parameter logic [7:0] ACK          = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*CMD_BYTES-1:0] cmd_in,
    input  logic                   cmd_vld,
    output logic                   cmd_rdy,
    input  logic                   flush,
    output logic [7:0]             tx_data,
    output logic                   trmt,
    input  logic                   tx_done,
    input  logic [7:0]             rx_data,
    input  logic                   rx_rdy,
    output logic                   clr_rx_rdy,
    output logic                   busy,
    output logic [7:0]             resp,
    output logic                   resp_vld,
    output logic [15:0]            ack_cnt,
    output logic [15:0]            nack_cnt,
    output logic [15:0]            tmo_cnt
);
    localparam int CW   = 8 * CMD_BYTES;
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int IW   = $clog2(CMD_BYTES + 1);
    localparam int TW   = $clog2(TIMEOUT_CLKS + 1);
    localparam int RW   = $clog2(MAX_RETRY + 2);

    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(DEPTH);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(CMD_BYTES);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [RW-1:0]   RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND      = 2'd1;
    localparam logic [1:0] WAIT_TX   = 2'd2;
    localparam logic [1:0] WAIT_RESP = 2'd3;

    logic [CW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, rd_nxt;
    logic [CNTW-1:0] count;
    logic            full, empty, push, pop, keep;
    logic [1:0]      state;
    logic [CW-1:0]   cmd_q, shreg;
    logic [IW-1:0]   byte_idx;
    logic [TW-1:0]   tmo;
    logic [RW-1:0]   retry;
    logic            rx_new, resp_in, tmo_hit, fail, can_retry;

    // rx_rdy is still high in the cycle our clear is on the wire; don't count it twice.
    assign rx_new    = rx_rdy && !clr_rx_rdy;
    assign resp_in   = (state == WAIT_RESP) && rx_new;
    assign tmo_hit   = (state == WAIT_RESP) && !rx_new && (tmo == TMO_LAST);
    assign fail      = resp_in ? (rx_data != ACK) : tmo_hit;
    assign can_retry = retry < RETRY_MAX;
    assign pop       = (resp_in || tmo_hit) && !(fail && can_retry);

    assign full    = count == FULL_CNT;
    assign empty   = count == '0;
    assign cmd_rdy = !full;
    assign busy    = state != IDLE;
    assign push    = cmd_vld && !full && !flush;
    assign rd_nxt  = rd_ptr + AW'(pop);
    assign keep    = busy && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cmd_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            // Flush while busy retains only the in-flight head so it can still be popped.
            if (flush) begin
                wr_ptr <= rd_nxt + AW'(keep);
                count  <= CNTW'(keep);
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                count <= count + CNTW'(push) - CNTW'(pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_q      <= '0;
            shreg      <= '0;
            byte_idx   <= '0;
            tmo        <= '0;
            retry      <= '0;
            tx_data    <= '0;
            trmt       <= 1'b0;
            clr_rx_rdy <= 1'b0;
            resp       <= '0;
            resp_vld   <= 1'b0;
            ack_cnt    <= '0;
            nack_cnt   <= '0;
            tmo_cnt    <= '0;
        end else begin
            trmt       <= 1'b0;
            resp_vld   <= 1'b0;
            clr_rx_rdy <= rx_new;
            case (state)
                IDLE: begin
                    if (!empty && !flush) begin
                        cmd_q    <= mem[rd_ptr];
                        shreg    <= mem[rd_ptr];
                        byte_idx <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    trmt     <= 1'b1;
                    tx_data  <= shreg[CW-1 -: 8];
                    shreg    <= shreg << 8;
                    byte_idx <= byte_idx + 1'b1;
                    state    <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        if (byte_idx == LAST_IDX) begin
                            tmo   <= '0;
                            state <= WAIT_RESP;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                WAIT_RESP: begin
                    tmo <= tmo + 1'b1;
                    if (resp_in || tmo_hit) begin
                        if (fail && can_retry) begin
                            retry    <= retry + 1'b1;
                            shreg    <= cmd_q;
                            byte_idx <= '0;
                            state    <= SEND;
                        end else begin
                            retry <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (resp_in) begin
                resp     <= rx_data;
                resp_vld <= 1'b1;
            end
            if (pop) begin
                if (!fail) begin
                    if (ack_cnt != 16'hFFFF) ack_cnt <= ack_cnt + 1'b1;
                end else if (resp_in) begin
                    if (nack_cnt != 16'hFFFF) nack_cnt <= nack_cnt + 1'b1;
                end else begin
                    if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_remote_cmd_sequencer.sv
// Bench for remote_cmd_sequencer: directed scenarios plus random traffic,
// checked every cycle against a queue-based transaction model.
module tb_remote_cmd_sequencer;
    localparam int         CB   = 2;
    localparam int         DEP  = 4;
    localparam int         TMO  = 100;
    localparam int         MR   = 1;
    localparam logic [7:0] ACKB = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cmd_in;
    logic        cmd_vld, cmd_rdy, flush;
    logic [7:0]  tx_data;
    logic        trmt, tx_done;
    logic [7:0]  rx_data;
    logic        rx_rdy, clr_rx_rdy, busy;
    logic [7:0]  resp;
    logic        resp_vld;
    logic [15:0] ack_cnt, nack_cnt, tmo_cnt;

    remote_cmd_sequencer #(.CMD_BYTES(CB), .DEPTH(DEP), .TIMEOUT_CLKS(TMO),
                           .MAX_RETRY(MR), .ACK(ACKB)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .flush(flush), .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy), .busy(busy),
        .resp(resp), .resp_vld(resp_vld), .ack_cnt(ack_cnt), .nack_cnt(nack_cnt),
        .tmo_cnt(tmo_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int total = 0, bad = 0;
    int cyc = 0;

    // Transaction model
    logic [15:0] fq[$];
    logic [7:0]  tx_log[$];
    int          plan[$];
    bit          inflight;
    int          exp_trmt_cyc, evt_cyc, evt_byte, resp_vld_cyc, clr_cyc;
    int          retry_m, ack_m, nack_m, tmo_m;
    logic [7:0]  resp_m;
    int          tx_cnt, tx_idx;
    bit          tx_stall, push_req, flush_req, stray_req;
    logic [15:0] push_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", tag, got, want, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        fq.delete(); plan.delete();
        inflight = 0; exp_trmt_cyc = -1; evt_cyc = -1; evt_byte = -1;
        resp_vld_cyc = -1; clr_cyc = -1; retry_m = 0;
        ack_m = 0; nack_m = 0; tmo_m = 0; resp_m = 8'h00;
        tx_cnt = 0; tx_idx = 0; tx_stall = 0;
        push_req = 0; flush_req = 0; stray_req = 0; push_data = '0;
        cmd_vld = 0; cmd_in = '0; flush = 0; tx_done = 0; rx_rdy = 0; rx_data = '0;
    endtask

    task automatic tick();
        logic [15:0] hd;
        bit busy_now, pop_m, acc;
        int r;
        @(negedge clk);
        cyc++;
        chk("trmt", trmt, cyc == exp_trmt_cyc);
        if (trmt) begin
            tx_log.push_back(tx_data);
            if (fq.size() > 0) begin
                hd = fq[0];
                chk("tx_data", tx_data, 8'(hd >> (8 * (CB - 1 - tx_idx))));
            end
        end
        chk("busy", busy, inflight);
        chk("cmd_rdy", cmd_rdy, fq.size() < DEP);
        chk("resp_vld", resp_vld, cyc == resp_vld_cyc);
        chk("clr_rx_rdy", clr_rx_rdy, cyc == clr_cyc);
        chk("resp", resp, resp_m);
        chk("ack_cnt", ack_cnt, ack_m);
        chk("nack_cnt", nack_cnt, nack_m);
        chk("tmo_cnt", tmo_cnt, tmo_m);

        cmd_vld = push_req && rst_n;
        cmd_in  = push_data;
        flush   = flush_req;
        tx_done = 0;
        if (clr_rx_rdy) rx_rdy = 0;
        if (rst_n) begin
            busy_now = inflight;
            pop_m = 0;
            if (trmt) tx_cnt = $urandom_range(1, 3);
            else if (tx_cnt > 0 && !tx_stall) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_done = 1;
                    tx_idx++;
                    if (tx_idx < CB) exp_trmt_cyc = cyc + 2;
                    else begin
                        tx_idx = 0;
                        if (plan.size() > 0) r = plan.pop_front();
                        else case ($urandom_range(0, 3))
                            0, 1: r = ACKB;
                            2: begin
                                r = $urandom_range(0, 255);
                                if (r == ACKB) r = 8'h5A;
                            end
                            default: r = -1;
                        endcase
                        evt_byte = r;
                        evt_cyc  = (r < 0) ? cyc + TMO : cyc + $urandom_range(1, 20);
                    end
                end
            end
            if (stray_req) begin
                rx_rdy = 1; rx_data = 8'($urandom); clr_cyc = cyc + 1;
            end
            if (cyc == evt_cyc) begin
                evt_cyc = -1;
                if (evt_byte >= 0) begin
                    rx_rdy = 1; rx_data = 8'(evt_byte); resp_m = 8'(evt_byte);
                    clr_cyc = cyc + 1; resp_vld_cyc = cyc + 1;
                end
                if (evt_byte == ACKB) begin
                    ack_m = sat(ack_m); pop_m = 1;
                end else if (retry_m < MR) begin
                    retry_m++; exp_trmt_cyc = cyc + 2;
                end else begin
                    if (evt_byte >= 0) nack_m = sat(nack_m);
                    else tmo_m = sat(tmo_m);
                    pop_m = 1;
                end
                if (pop_m) retry_m = 0;
            end
            acc = push_req && fq.size() < DEP && !flush_req;
            if (!busy_now && fq.size() > 0 && !flush_req) begin
                inflight = 1; exp_trmt_cyc = cyc + 2; tx_idx = 0;
            end
            if (pop_m) begin
                void'(fq.pop_front());
                inflight = 0;
            end
            if (flush_req) begin
                if (busy_now && !pop_m) begin
                    hd = fq[0]; fq.delete(); fq.push_back(hd);
                end else fq.delete();
            end
            if (acc) fq.push_back(push_data);
        end
        push_req = 0; flush_req = 0; stray_req = 0;
    endtask

    task automatic push_cmd(input logic [15:0] d);
        push_req = 1; push_data = d;
        tick();
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((fq.size() > 0 || inflight || evt_cyc >= 0) && n < lim) begin
            tick(); n++;
        end
        chk("idle_bound", n < lim, 1);
        repeat (2) tick();
    endtask

    logic [15:0] pd[5];
    int n;

    initial begin
        rst_n = 0;
        model_reset();
        repeat (3) tick();
        chk("rst_cmd_rdy", cmd_rdy, 1);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp", resp, 0);
        rst_n = 1;
        tick();

        // Stray byte while idle
        stray_req = 1;
        repeat (4) tick();
        chk("stray_resp", resp, 0);
        chk("stray_ack", ack_cnt, 0);

        // Single command, acked
        tx_log.delete();
        plan.push_back(ACKB);
        push_cmd(16'h2000);
        wait_idle(300);
        chk("t1_n", tx_log.size(), 2);
        if (tx_log.size() == 2) begin
            chk("t1_b0", tx_log[0], 8'h20);
            chk("t1_b1", tx_log[1], 8'h00);
        end
        chk("t1_ack", ack_cnt, 1);
        chk("t1_busy", busy, 0);
        chk("t1_rdy", cmd_rdy, 1);

        // Fill FIFO with a stalled transmitter; 5th push must be dropped
        tx_log.delete();
        tx_stall = 1;
        for (int i = 0; i < 5; i++) begin
            pd[i] = 16'($urandom);
            push_cmd(pd[i]);
        end
        chk("t2_full", cmd_rdy, 0);
        repeat (5) tick();
        tx_stall = 0;
        repeat (4) plan.push_back(ACKB);
        wait_idle(500);
        chk("t2_n", tx_log.size(), 8);
        if (tx_log.size() == 8)
            for (int i = 0; i < 4; i++) begin
                chk("t2_hi", tx_log[2*i], pd[i][15:8]);
                chk("t2_lo", tx_log[2*i+1], pd[i][7:0]);
            end
        chk("t2_ack", ack_cnt, 5);

        // NACK then ACK: one resend
        tx_log.delete();
        plan.push_back(8'h5A); plan.push_back(ACKB);
        push_cmd(16'hBEEF);
        wait_idle(400);
        chk("t3_n", tx_log.size(), 4);
        chk("t3_ack", ack_cnt, 6);
        chk("t3_nack", nack_cnt, 0);
        chk("t3_resp", resp, 8'hA5);

        // Two timeouts drop the first command, second proceeds
        plan.push_back(-1); plan.push_back(-1); plan.push_back(ACKB);
        push_cmd(16'h1234);
        push_cmd(16'h5678);
        wait_idle(800);
        chk("t4_tmo", tmo_cnt, 1);
        chk("t4_ack", ack_cnt, 7);

        // Flush during the first command's response wait
        tx_log.delete();
        plan.push_back(ACKB);
        for (int i = 0; i < 4; i++) push_cmd(16'($urandom));
        n = 0;
        while (evt_cyc < 0 && n < 200) begin tick(); n++; end
        chk("t6_reach", n < 200, 1);
        flush_req = 1;
        push_req = 1; push_data = 16'hDEAD;
        tick();
        wait_idle(300);
        chk("t6_ack", ack_cnt, 8);
        chk("t6_n", tx_log.size(), 2);
        chk("t6_rdy", cmd_rdy, 1);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                push_req = 1; push_data = 16'($urandom);
            end
            tick();
        end
        wait_idle(5000);

        // Reset while in WAIT_TX
        push_cmd(16'hC0DE);
        push_cmd(16'hF00D);
        n = 0;
        while (tx_cnt == 0 && n < 50) begin tick(); n++; end
        chk("t7_reach", n < 50, 1);
        rst_n = 0;
        #1;
        chk("t7_rdy", cmd_rdy, 1);
        chk("t7_txd", tx_data, 0);
        chk("t7_trmt", trmt, 0);
        chk("t7_clr", clr_rx_rdy, 0);
        chk("t7_busy", busy, 0);
        chk("t7_resp", resp, 0);
        chk("t7_rvld", resp_vld, 0);
        chk("t7_cnts", {ack_cnt, nack_cnt | tmo_cnt}, 0);
        model_reset();
        repeat (2) tick();
        rst_n = 1;
        tx_log.delete();
        repeat (30) tick();
        chk("t7_no_tx", tx_log.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
